// File: rtl/frog_pkg.sv
// Shared definitions for the frogger button conditioning path: FSM encoding,
// direction indices and default timing constants.
package frog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

    localparam int UP       = 0;
    localparam int DOWN     = 1;
    localparam int LEFT     = 2;
    localparam int RIGHT    = 3;
    localparam int NUM_DIRS = 4;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 25_000_000;

    // One counter width covers every timing value; each counter only ever holds param-1.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: 2-flop synchroniser, debounce filter and hold/auto-repeat FSM
// producing a single-cycle move request (active-high) per accepted move.
module button_debounce
    import frog_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic req
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_debounce: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 2) begin : g_bad_delay
        $error("button_debounce: REPEAT_DELAY must be at least 2");
    end
    if (REPEAT_PERIOD < 2) begin : g_bad_period
        $error("button_debounce: REPEAT_PERIOD must be at least 2");
    end

    logic sync_p0;
    logic sync_p1;

    // Stage p0/p1: metastability guard, released (1) out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

    logic [CNT_W-1:0] deb_cnt;
    logic             stable;

    // Stage p2: accept a new level only after it persists for DEBOUNCE_CYCLES samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_cnt <= '0;
            stable  <= 1'b1;
        end else if (sync_p1 == stable) begin
            deb_cnt <= '0;
        end else if (deb_cnt >= DEB_LAST) begin
            stable  <= sync_p1;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    btn_state_t       state;
    btn_state_t       state_nxt;
    logic [CNT_W-1:0] rpt_cnt;
    logic [CNT_W-1:0] rpt_cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            rpt_cnt <= '0;
        end else begin
            state   <= state_nxt;
            rpt_cnt <= rpt_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rpt_cnt_nxt = rpt_cnt;
        req         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!stable) begin
                    req         = 1'b1;
                    state_nxt   = ST_HOLD;
                    rpt_cnt_nxt = DELAY_LOAD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                // A release wins over a due repeat so no move follows the release.
                if (stable) begin
                    state_nxt   = ST_IDLE;
                    rpt_cnt_nxt = '0;
                end else if (rpt_cnt == '0) begin
                    req         = 1'b1;
                    state_nxt   = ST_REPEAT;
                    rpt_cnt_nxt = PERIOD_LOAD;
                end else begin
                    rpt_cnt_nxt = rpt_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                rpt_cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: rtl/frog_input_conditioner.sv
// Turns the four raw active-low frogger buttons into active-low single-cycle
// move strobes with auto-repeat; at most one direction strobes per cycle.
module frog_input_conditioner
    import frog_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic up,
    input  logic down,
    input  logic left,
    input  logic right,
    output logic up_out,
    output logic down_out,
    output logic left_out,
    output logic right_out
);

    logic [NUM_DIRS-1:0] raw;
    logic [NUM_DIRS-1:0] req;
    logic [NUM_DIRS-1:0] grant;
    logic [NUM_DIRS-1:0] strobe_n_p1;

    assign raw[UP]    = up;
    assign raw[DOWN]  = down;
    assign raw[LEFT]  = left;
    assign raw[RIGHT] = right;

    for (genvar d = 0; d < NUM_DIRS; d++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_btn (
            .clk  (clk),
            .reset(reset),
            .btn  (raw[d]),
            .req  (req[d])
        );
    end

    // Fixed priority; losers are dropped, their FSMs keep counting toward the next repeat.
    always_comb begin
        grant = '0;
        if (req[UP])         grant[UP]    = 1'b1;
        else if (req[DOWN])  grant[DOWN]  = 1'b1;
        else if (req[LEFT])  grant[LEFT]  = 1'b1;
        else if (req[RIGHT]) grant[RIGHT] = 1'b1;
    end

    // Stage p1: registered active-low strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strobe_n_p1 <= '1;
        end else begin
            strobe_n_p1 <= ~grant;
        end
    end

    assign up_out    = strobe_n_p1[UP];
    assign down_out  = strobe_n_p1[DOWN];
    assign left_out  = strobe_n_p1[LEFT];
    assign right_out = strobe_n_p1[RIGHT];

endmodule
